// File: rtl/monster_fleet_ctrl.sv
// Space Monsters gameplay controller: marches the formation, tracks which
// monsters are alive, accumulates a saturating score and reports the
// win / tank_destroyed events back to the level state machine.
module monster_fleet_ctrl #(
  parameter int NUM_MON     = 8,
  parameter int STEP_DIV_L1 = 2_500_000,
  parameter int STEP_DIV_L2 = 1_250_000,
  parameter int X_MIN       = 160,
  parameter int X_MAX       = 480,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int Y_START     = 64,
  parameter int Y_LIMIT     = 400,
  parameter int PTS_L1      = 1,
  parameter int PTS_L2      = 2,
  localparam int IW         = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         level_in,
  input  logic               hit_valid,
  input  logic [IW-1:0]      hit_idx,
  input  logic               tank_hit,
  output logic [9:0]         fleet_x,
  output logic [9:0]         fleet_y,
  output logic [NUM_MON-1:0] alive,
  output logic               win,
  output logic               tank_destroyed,
  output logic [7:0]         score,
  output logic               playing
);

  localparam int DIV_MAX = (STEP_DIV_L1 > STEP_DIV_L2) ? STEP_DIV_L1 : STEP_DIV_L2;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DIV_W-1:0] TC_L1 = DIV_W'(STEP_DIV_L1 - 1);
  localparam logic [DIV_W-1:0] TC_L2 = DIV_W'(STEP_DIV_L2 - 1);

  localparam logic [10:0] X_MAX_E  = 11'(X_MAX);
  localparam logic [10:0] X_LEFT_E = 11'(X_MIN + STEP_X);
  localparam logic [10:0] STEP_X_E = 11'(STEP_X);

  localparam logic [9:0] X_MIN_W   = 10'(X_MIN);
  localparam logic [9:0] Y_START_W = 10'(Y_START);
  localparam logic [9:0] Y_LIMIT_W = 10'(Y_LIMIT);
  localparam logic [9:0] STEP_X_W  = 10'(STEP_X);
  localparam logic [9:0] STEP_Y_W  = 10'(STEP_Y);

  localparam logic [7:0] PTS1 = 8'(PTS_L1);
  localparam logic [7:0] PTS2 = 8'(PTS_L2);

  localparam logic [NUM_MON-1:0] ONE_HOT0 = NUM_MON'(1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t             state;
  logic [2:0]         lvl_q;
  logic [DIV_W-1:0]   divider;
  logic               dir_left;

  logic [2:0]         lvl;
  logic               load;
  logic               step_tc;
  logic [7:0]         pts;
  logic [NUM_MON-1:0] hit_mask;
  logic               hit_ok;
  logic               last_kill;
  logic               at_right;
  logic               at_left;
  logic               fail;

  // Score accumulation clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Decode level, step timing, hit qualification and edge/fail conditions.
  always_comb begin
    lvl       = (level_in == 3'd1 || level_in == 3'd2) ? level_in : 3'd0;
    load      = (lvl != 3'd0) && (lvl != lvl_q);
    step_tc   = (lvl_q == 3'd2) ? (divider == TC_L2) : (divider == TC_L1);
    pts       = (lvl_q == 3'd2) ? PTS2 : PTS1;
    // An out-of-range index shifts the bit off the top, so it never matches.
    hit_mask  = ONE_HOT0 << hit_idx;
    hit_ok    = hit_valid && ((alive & hit_mask) != '0);
    last_kill = hit_ok && ((alive & ~hit_mask) == '0);
    at_right  = ({1'b0, fleet_x} + STEP_X_E) > X_MAX_E;
    at_left   = {1'b0, fleet_x} < X_LEFT_E;
    fail      = tank_hit || (fleet_y >= Y_LIMIT_W);
  end

  // Level FSM with registered fleet position, alive mask, score and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      lvl_q          <= 3'd0;
      divider        <= '0;
      dir_left       <= 1'b0;
      fleet_x        <= X_MIN_W;
      fleet_y        <= Y_START_W;
      alive          <= '0;
      win            <= 1'b0;
      tank_destroyed <= 1'b0;
      score          <= 8'd0;
      playing        <= 1'b0;
    end else begin
      lvl_q          <= lvl;
      win            <= 1'b0;
      tank_destroyed <= 1'b0;
      if (load) begin
        // A new level code reloads the formation from any state; score carries over.
        state    <= S_PLAY;
        playing  <= 1'b1;
        alive    <= '1;
        fleet_x  <= X_MIN_W;
        fleet_y  <= Y_START_W;
        dir_left <= 1'b0;
        divider  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (lvl == 3'd0) score <= 8'd0;
          end
          S_PLAY: begin
            if (lvl == 3'd0) begin
              state   <= S_IDLE;
              playing <= 1'b0;
            end else begin
              divider <= step_tc ? '0 : divider + DIV_W'(1);
              if (step_tc) begin
                if (!dir_left && at_right) begin
                  fleet_y  <= fleet_y + STEP_Y_W;
                  dir_left <= 1'b1;
                end else if (dir_left && at_left) begin
                  fleet_y  <= fleet_y + STEP_Y_W;
                  dir_left <= 1'b0;
                end else if (dir_left) begin
                  fleet_x <= fleet_x - STEP_X_W;
                end else begin
                  fleet_x <= fleet_x + STEP_X_W;
                end
              end
              if (hit_ok) begin
                alive <= alive & ~hit_mask;
                score <= sat_add(score, pts);
              end
              // Losing the tank outranks clearing the fleet in the same cycle.
              if (fail) begin
                tank_destroyed <= 1'b1;
                state          <= S_DONE;
                playing        <= 1'b0;
              end else if (last_kill) begin
                win     <= 1'b1;
                state   <= S_DONE;
                playing <= 1'b0;
              end
            end
          end
          S_DONE: begin
            if (lvl == 3'd0) state <= S_IDLE;
          end
          default: begin
            state   <= S_IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
